axi4lite_slave_regs: RTL and testbench

AXI4-Lite slave register file: the downstream target of the team's AXI4-Lite master wrapper, consuming its AW/W/B/AR/R channels one-to-one. It holds three read/write control registers, driven out to fabric, plus one read-only counter of committed writes. AW and W are accepted independently and buffered. Write and read paths run concurrently with single-cycle response latency.

---
 rtl/axi4lite_slave_regs.sv | 177 +++++++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave: three RW control registers plus a RO committed-write counter.
// Optional AXI_SLV_ADDR_CHECK_EN: SLVERR on misaligned access and writes to 0xC.
module axi4lite_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]                    awprot,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] wdata,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]                    arprot,
    input  logic                          arvalid,
    output logic                          arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                    rresp,
    output logic                          rvalid,
    input  logic                          rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl1,
    output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl2
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    logic          ready_en_q;
    logic          aw_full_q;
    logic [AW-1:0] aw_addr_q;
    logic          w_full_q;
    logic [DW-1:0] w_data_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;
    logic [DW-1:0] ctrl0_q;
    logic [DW-1:0] ctrl1_q;
    logic [DW-1:0] ctrl2_q;
    logic [DW-1:0] wr_count_q;

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          commit;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_idx;
    logic          wr_err;
    logic [1:0]    rd_idx;
    logic          rd_err;
    logic [DW-1:0] rd_word;
    logic          unused_sig;

    assign awready = ready_en_q & ~aw_full_q;
    assign wready  = ready_en_q & ~w_full_q;
    assign arready = ready_en_q & (~rvalid_q | rready);

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;

    // A held beat takes priority; otherwise the live handshake is used directly.
    assign wr_addr = aw_full_q ? aw_addr_q : awaddr;
    assign wr_data = w_full_q ? w_data_q : wdata;
    assign wr_idx  = wr_addr[3:2];
    assign rd_idx  = araddr[3:2];

    assign commit = (aw_full_q | aw_hs) & (w_full_q | w_hs)
                  & (~bvalid_q | bready);

`ifdef AXI_SLV_ADDR_CHECK_EN
    assign wr_err = (wr_idx == 2'd3) | (wr_addr[1:0] != 2'b00);
    assign rd_err = (araddr[1:0] != 2'b00);
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    assign unused_sig = ^{awprot, arprot, wr_addr, araddr};

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign ctrl0  = ctrl0_q;
    assign ctrl1  = ctrl1_q;
    assign ctrl2  = ctrl2_q;

    // Read mux; erroring reads return zero data.
    always_comb begin
        rd_word = '0;
        case (rd_idx)
            2'd0:    rd_word = ctrl0_q;
            2'd1:    rd_word = ctrl1_q;
            2'd2:    rd_word = ctrl2_q;
            default: rd_word = wr_count_q;
        endcase
        if (rd_err) rd_word = '0;
    end

    // Readies stay low until one edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ready_en_q <= 1'b0;
        else          ready_en_q <= 1'b1;
    end

    // AW/W holding buffers, write response and commit counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_count_q <= '0;
        end else if (commit) begin
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_err ? 2'b10 : 2'b00;
            wr_count_q <= wr_count_q + DW'(1);
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= wdata;
            end
            if (bvalid_q && bready) bvalid_q <= 1'b0;
        end
    end

    // Control register update on an error-free commit; index 3 is read-only.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl0_q <= '0;
            ctrl1_q <= '0;
            ctrl2_q <= '0;
        end else if (commit && !wr_err) begin
            case (wr_idx)
                2'd0:    ctrl0_q <= wr_data;
                2'd1:    ctrl1_q <= wr_data;
                2'd2:    ctrl2_q <= wr_data;
                default: ;
            endcase
        end
    end

    // Read channel: register the addressed word on each AR handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= rd_err ? 2'b10 : 2'b00;
        end else if (rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Testbench for axi4lite_slave_regs: directed literal checks plus random
// traffic compared every cycle against a transaction-level model.
module tb_axi4lite_slave_regs;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] ctrl0;
    logic [31:0] ctrl1;
    logic [31:0] ctrl2;

    always #5 aclk = ~aclk;

    axi4lite_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rready(rready),
        .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2)
    );

    int checks = 0;
    int errors = 0;

`ifdef AXI_SLV_ADDR_CHECK_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Transaction-level model
    logic [31:0] m_regs[3];
    logic [31:0] m_cnt;
    logic        m_en;
    logic [3:0]  m_awq[$];
    logic [31:0] m_wq[$];
    logic        m_bv;
    logic [1:0]  m_br;
    logic        m_rv;
    logic [31:0] m_rd;
    logic [1:0]  m_rr;

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_regs[i] = '0;
        m_cnt = '0;
        m_en = 1'b0;
        m_awq.delete();
        m_wq.delete();
        m_bv = 1'b0;
        m_br = 2'b00;
        m_rv = 1'b0;
        m_rd = '0;
        m_rr = 2'b00;
    endtask

    task automatic m_step(input logic aw_ok, input logic w_ok,
                          input logic ar_ok);
        logic [3:0]  a;
        logic [31:0] d;
        logic        bad;
        if (m_rv && rready) m_rv = 1'b0;
        if (arvalid && ar_ok) begin
            m_rv = 1'b1;
            m_rr = 2'b00;
            m_rd = (araddr[3:2] == 2'd3) ? m_cnt : m_regs[araddr[3:2]];
`ifdef AXI_SLV_ADDR_CHECK_EN
            if (araddr[1:0] != 2'b00) begin
                m_rr = 2'b10;
                m_rd = '0;
            end
`endif
        end
        if (awvalid && aw_ok) m_awq.push_back(awaddr);
        if (wvalid && w_ok) m_wq.push_back(wdata);
        if (m_awq.size() > 0 && m_wq.size() > 0 && (!m_bv || bready)) begin
            a = m_awq.pop_front();
            d = m_wq.pop_front();
            bad = 1'b0;
`ifdef AXI_SLV_ADDR_CHECK_EN
            bad = (a[3:2] == 2'd3) || (a[1:0] != 2'b00);
`endif
            if (!bad && a[3:2] != 2'd3) m_regs[a[3:2]] = d;
            m_cnt = m_cnt + 32'd1;
            m_bv = 1'b1;
            m_br = bad ? 2'b10 : 2'b00;
        end else if (m_bv && bready) begin
            m_bv = 1'b0;
        end
        m_en = 1'b1;
    endtask

    initial m_reset();

    // Per-cycle compare against the model, then advance it for the next edge.
    always @(negedge aclk) begin
        logic e_aw, e_w, e_ar;
        if (!aresetn) m_reset();
        e_aw = m_en && (m_awq.size() == 0);
        e_w  = m_en && (m_wq.size() == 0);
        e_ar = m_en && (!m_rv || rready);
        chk("awready", 32'(awready), 32'(e_aw));
        chk("wready", 32'(wready), 32'(e_w));
        chk("arready", 32'(arready), 32'(e_ar));
        chk("bvalid", 32'(bvalid), 32'(m_bv));
        if (m_bv) chk("bresp", 32'(bresp), 32'(m_br));
        chk("rvalid", 32'(rvalid), 32'(m_rv));
        if (m_rv) begin
            chk("rdata", rdata, m_rd);
            chk("rresp", 32'(rresp), 32'(m_rr));
        end
        chk("ctrl0", ctrl0, m_regs[0]);
        chk("ctrl1", ctrl1, m_regs[1]);
        chk("ctrl2", ctrl2, m_regs[2]);
        if (aresetn) m_step(e_aw, e_w, e_ar);
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        repeat (3) cyc();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_awready0", 32'(awready), 32'd0);
        chk("rel_arready0", 32'(arready), 32'd0);
        chk("rel_ctrl0", ctrl0, 32'd0);
        cyc();
        @(negedge aclk);
        chk("rel_awready1", 32'(awready), 32'd1);
        chk("rel_wready1", 32'(wready), 32'd1);
        cyc();

        araddr = 4'hC; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        @(negedge aclk);
        chk("rd_cnt0_v", 32'(rvalid), 32'd1);
        chk("rd_cnt0", rdata, 32'd0);
        chk("rd_cnt0_resp", 32'(rresp), 32'd0);
        cyc();

        awaddr = 4'h4; wdata = 32'hDEADBEEF;
        awvalid = 1'b1; wvalid = 1'b1;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        chk("wr1_bvalid", 32'(bvalid), 32'd1);
        chk("wr1_bresp", 32'(bresp), 32'd0);
        chk("wr1_ctrl1", ctrl1, 32'hDEADBEEF);
        cyc();
        chk("model_ctrl1", m_regs[1], 32'hDEADBEEF);

        araddr = 4'hC; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        @(negedge aclk);
        chk("rd_cnt1", rdata, 32'd1);
        cyc();

        wdata = 32'h12345678; wvalid = 1'b1;
        cyc();
        wvalid = 1'b0;
        cyc();
        @(negedge aclk);
        chk("wfirst_wready", 32'(wready), 32'd0);
        chk("wfirst_bvalid", 32'(bvalid), 32'd0);
        cyc();
        awaddr = 4'h8; awvalid = 1'b1;
        cyc();
        awvalid = 1'b0;
        @(negedge aclk);
        chk("wfirst_commit", 32'(bvalid), 32'd1);
        chk("wfirst_ctrl2", ctrl2, 32'h12345678);
        cyc();

        bready = 1'b0;
        awaddr = 4'h0; wdata = 32'h11111111;
        awvalid = 1'b1; wvalid = 1'b1;
        cyc();
        awaddr = 4'h4; wdata = 32'h22222222;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) cyc();
        @(negedge aclk);
        chk("stall_awready", 32'(awready), 32'd0);
        chk("stall_wready", 32'(wready), 32'd0);
        chk("stall_ctrl1", ctrl1, 32'hDEADBEEF);
        cyc();
        bready = 1'b1;
        cyc();
        @(negedge aclk);
        chk("stall_b2", 32'(bvalid), 32'd1);
        chk("stall_ctrl1b", ctrl1, 32'h22222222);
        cyc();
        @(negedge aclk);
        chk("stall_bdone", 32'(bvalid), 32'd0);
        cyc();
        araddr = 4'hC; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        @(negedge aclk);
        chk("rd_cnt4", rdata, 32'd4);
        cyc();

        awaddr = 4'h0; wdata = 32'hA5A5A5A5;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h0; arvalid = 1'b1;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 4'h0;
        @(negedge aclk);
        chk("rw_same_old", rdata, 32'h11111111);
        chk("rw_same_ctrl0", ctrl0, 32'hA5A5A5A5);
        cyc();
        araddr = 4'h4;
        @(negedge aclk);
        chk("b2b_rd0", rdata, 32'hA5A5A5A5);
        chk("b2b_rv0", 32'(rvalid), 32'd1);
        cyc();
        arvalid = 1'b0;
        @(negedge aclk);
        chk("b2b_rd1", rdata, 32'h22222222);
        chk("b2b_rv1", 32'(rvalid), 32'd1);
        cyc();

        awaddr = 4'hC; wdata = 32'hFFFFFFFF;
        awvalid = 1'b1; wvalid = 1'b1;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        chk("cfg_wr_bresp", 32'(bresp), 32'(ERR));
        cyc();
        araddr = 4'h5; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        @(negedge aclk);
        chk("cfg_rd_rresp", 32'(rresp), 32'(ERR));
`ifdef AXI_SLV_ADDR_CHECK_EN
        chk("cfg_rd_data", rdata, 32'd0);
`else
        chk("cfg_rd_data", rdata, 32'h22222222);
`endif
        cyc();
        araddr = 4'hC; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        @(negedge aclk);
        chk("rd_cnt6", rdata, 32'd6);
        cyc();
        chk("model_cnt", m_cnt, 32'd6);

        for (int i = 0; i < 4000; i++) begin
            awvalid = 1'($urandom);
            wvalid  = 1'($urandom);
            arvalid = 1'($urandom);
            awaddr  = 4'($urandom);
            araddr  = 4'($urandom);
            wdata   = $urandom;
            awprot  = 3'($urandom);
            arprot  = 3'($urandom);
            bready  = ($urandom_range(0, 3) != 0);
            rready  = ($urandom_range(0, 3) != 0);
            aresetn = ($urandom_range(0, 299) != 0);
            cyc();
        end
        aresetn = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
